msi_snoopy_controller: RTL and testbench



---
 rtl/msi_snoopy_controller.sv | 136 +++++++++++++
 tb/tb_msi_snoopy_controller.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msi_snoopy_controller.sv
// Bus-side MSI snoop responder for one private cache: looks up the snooped line,
// flushes Modified data word by word, downgrades or invalidates it, then acknowledges.
module msi_snoopy_controller #(
    parameter int         TAG_WIDTH         = 8,
    parameter int         INDEX_WIDTH       = 4,
    parameter int         OFFSET_WIDTH      = 2,
    parameter int         SET_ASSOCIATIVITY = 2,
    parameter int         DATA_WIDTH        = 16,
    parameter logic [1:0] INVALID_STATE     = 2'b00,
    parameter logic [1:0] SHARED_STATE      = 2'b01,
    parameter logic [1:0] MODIFIED_STATE    = 2'b10
) (
    input  logic                                        clock,
    input  logic                                        reset,
    // busRequest is valid and held until busAcknowledge; the bus drops it the cycle after.
    input  logic                                        busRequest,
    input  logic [1:0]                                  busCommand,
    input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] busAddress,
    output logic                                        busAcknowledge,
    output logic                                        busShared,
    output logic                                        busFlush,
    output logic                                        busDataValid,
    output logic [DATA_WIDTH-1:0]                       busDataOut,
    input  logic                                        busDataReady,
    output logic [INDEX_WIDTH-1:0]                      snoopyIndex,
    output logic [OFFSET_WIDTH-1:0]                     snoopyOffset,
    output logic [TAG_WIDTH-1:0]                        snoopyTagIn,
    output logic [1:0]                                  snoopyStateIn,
    output logic                                        snoopyWriteState,
    input  logic                                        snoopyHit,
    input  logic [1:0]                                  snoopyStateOut,
    input  logic [DATA_WIDTH-1:0]                       snoopyDataOut,
    output logic                                        invalidateEnable,
    output logic [4:0]                                  debugState
);

    localparam int ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;

    localparam logic [1:0] BUS_READ           = 2'd0;
    localparam logic [1:0] BUS_READ_EXCLUSIVE = 2'd1;
    localparam logic [1:0] BUS_INVALIDATE     = 2'd2;
    localparam logic [1:0] BUS_NONE           = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        FLUSH   = 3'd2,
        UPDATE  = 3'd3,
        RESPOND = 3'd4
    } snoopState_t;

    if (SET_ASSOCIATIVITY < 1) begin : gBadAssociativity
        $error("SET_ASSOCIATIVITY must be at least 1");
    end

    snoopState_t              state;
    logic [ADDR_WIDTH-1:0]    addressReg;
    logic [1:0]               commandReg;
    logic                     hitReg;
    logic [1:0]               stateReg;
    logic [OFFSET_WIDTH-1:0]  offsetCount;

    logic       lookupHit;
    logic [1:0] nextLineState;

    // A tag match on an Invalid line is a miss for coherence purposes.
    assign lookupHit     = snoopyHit && (snoopyStateOut != INVALID_STATE);
    assign nextLineState = (commandReg == BUS_READ) ? SHARED_STATE : INVALID_STATE;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            addressReg  <= '0;
            commandReg  <= BUS_READ;
            hitReg      <= 1'b0;
            stateReg    <= INVALID_STATE;
            offsetCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (busRequest) begin
                        addressReg <= busAddress;
                        commandReg <= busCommand;
                        state      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hitReg   <= lookupHit;
                    stateReg <= snoopyStateOut;
                    if (commandReg == BUS_NONE || !lookupHit) begin
                        state <= RESPOND;
                    end else if (snoopyStateOut == MODIFIED_STATE) begin
                        offsetCount <= '0;
                        state       <= FLUSH;
                    end else begin
                        state <= UPDATE;
                    end
                end
                FLUSH: begin
                    // Word and counter hold while the bus stalls; the last word wraps the counter.
                    if (busDataReady) begin
                        offsetCount <= offsetCount + 1'b1;
                        if (offsetCount == '1) begin
                            state <= UPDATE;
                        end
                    end
                end
                UPDATE:  state <= RESPOND;
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign snoopyIndex      = addressReg[OFFSET_WIDTH +: INDEX_WIDTH];
    assign snoopyTagIn      = addressReg[OFFSET_WIDTH+INDEX_WIDTH +: TAG_WIDTH];
    assign snoopyOffset     = (state == FLUSH) ? offsetCount : addressReg[OFFSET_WIDTH-1:0];

    assign busFlush         = (state == FLUSH);
    assign busDataValid     = (state == FLUSH);
    assign busDataOut       = (state == FLUSH) ? snoopyDataOut : '0;

    assign snoopyWriteState = (state == UPDATE);
    assign snoopyStateIn    = (state == UPDATE) ? nextLineState : INVALID_STATE;
    assign invalidateEnable = (state == UPDATE) && (nextLineState == INVALID_STATE);

    assign busAcknowledge   = (state == RESPOND);
    assign busShared        = (state == RESPOND) && hitReg;

    assign debugState       = {stateReg, state};

    // Both remaining commands invalidate; named here so the encodings stay documented together.
    logic unusedCommands;
    assign unusedCommands = (commandReg == BUS_READ_EXCLUSIVE) || (commandReg == BUS_INVALIDATE);

endmodule

// File: tb/tb_msi_snoopy_controller.sv
// Directed bench for msi_snoopy_controller: a one-line cache model answers lookups,
// a negedge monitor records bus and cache-port activity, and assertions check each step.
module tb_msi_snoopy_controller;

    localparam int AW = 14;
    localparam int DW = 16;

    localparam logic [1:0] INV = 2'b00;
    localparam logic [1:0] SHR = 2'b01;
    localparam logic [1:0] MOD = 2'b10;

    localparam logic [1:0] CMD_READ  = 2'd0;
    localparam logic [1:0] CMD_READX = 2'd1;
    localparam logic [1:0] CMD_INV   = 2'd2;
    localparam logic [1:0] CMD_NONE  = 2'd3;

    logic          clock;
    logic          reset;
    logic          busRequest;
    logic [1:0]    busCommand;
    logic [AW-1:0] busAddress;
    logic          busAcknowledge;
    logic          busShared;
    logic          busFlush;
    logic          busDataValid;
    logic [DW-1:0] busDataOut;
    logic          busDataReady;
    logic [3:0]    snoopyIndex;
    logic [1:0]    snoopyOffset;
    logic [7:0]    snoopyTagIn;
    logic [1:0]    snoopyStateIn;
    logic          snoopyWriteState;
    logic          snoopyHit;
    logic [1:0]    snoopyStateOut;
    logic [DW-1:0] snoopyDataOut;
    logic          invalidateEnable;
    logic [4:0]    debugState;

    msi_snoopy_controller dut (
        .clock            (clock),
        .reset            (reset),
        .busRequest       (busRequest),
        .busCommand       (busCommand),
        .busAddress       (busAddress),
        .busAcknowledge   (busAcknowledge),
        .busShared        (busShared),
        .busFlush         (busFlush),
        .busDataValid     (busDataValid),
        .busDataOut       (busDataOut),
        .busDataReady     (busDataReady),
        .snoopyIndex      (snoopyIndex),
        .snoopyOffset     (snoopyOffset),
        .snoopyTagIn      (snoopyTagIn),
        .snoopyStateIn    (snoopyStateIn),
        .snoopyWriteState (snoopyWriteState),
        .snoopyHit        (snoopyHit),
        .snoopyStateOut   (snoopyStateOut),
        .snoopyDataOut    (snoopyDataOut),
        .invalidateEnable (invalidateEnable),
        .debugState       (debugState)
    );

    // Clock and cycle counter
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // One-line cache model
    logic          mValid;
    logic [7:0]    mTag;
    logic [3:0]    mIndex;
    logic [1:0]    mState;
    logic [DW-1:0] mData [4];

    assign snoopyHit      = mValid && (snoopyTagIn == mTag) && (snoopyIndex == mIndex);
    assign snoopyStateOut = snoopyHit ? mState : INV;
    assign snoopyDataOut  = snoopyHit ? mData[snoopyOffset] : '0;

    // Monitor
    int            reqCycle = 0;
    int            writeCount = 0;
    int            invCount = 0;
    int            invWithWrite = 0;
    int            writeRel = 0;
    int            ackCount = 0;
    int            flushSkew = 0;
    logic [1:0]    lastWriteState = INV;
    logic [DW-1:0] gotQ[$];
    logic [DW-1:0] stallQ[$];
    int            wordRel[$];

    always @(negedge clock) begin
        if (busAcknowledge) ackCount <= ackCount + 1;
        if (snoopyWriteState) begin
            writeCount     <= writeCount + 1;
            lastWriteState <= snoopyStateIn;
            writeRel       <= cyc - reqCycle;
            if (invalidateEnable) invWithWrite <= invWithWrite + 1;
        end
        if (invalidateEnable) invCount <= invCount + 1;
        if (busDataValid) begin
            if (busDataReady) begin
                gotQ.push_back(busDataOut);
                wordRel.push_back(cyc - reqCycle);
            end else begin
                stallQ.push_back(busDataOut);
            end
        end
        if (busFlush != busDataValid) flushSkew <= flushSkew + 1;
    end

    // Scoreboard state
    int            assertCount = 0;
    int            failCount = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] expWord;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Driver tasks
    task automatic runTxn(input logic [1:0] cmd, input logic [AW-1:0] addr,
                          input int stallLo, input int stallHi,
                          output int latency, output logic shared);
        logic done;
        done    = 1'b0;
        latency = -1;
        shared  = 1'b0;
        @(posedge clock); #1;
        busRequest   = 1'b1;
        busCommand   = cmd;
        busAddress   = addr;
        reqCycle     = cyc;
        busDataReady = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clock);
            if (busAcknowledge) begin
                done    = 1'b1;
                latency = cyc - reqCycle;
                shared  = busShared;
            end else begin
                @(posedge clock); #1;
                busDataReady = !(((cyc - reqCycle) >= stallLo) && ((cyc - reqCycle) <= stallHi));
            end
        end
        check("ack_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic endReq();
        @(posedge clock); #1;
        busRequest   = 1'b0;
        busCommand   = CMD_NONE;
        busDataReady = 1'b0;
    endtask

    task automatic checkFlushWords(input string tag, input int base, input int firstRel, input logic stalled);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'hA000 + DW'(i));
        check({tag, "_word_count"}, gotQ.size() - base, 4);
        if (gotQ.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                expWord = exp_q.pop_front();
                check($sformatf("%s_word%0d", tag, i), gotQ[base+i], expWord);
                if (!stalled) check($sformatf("%s_word%0d_cycle", tag, i), wordRel[base+i], firstRel + i);
            end
        end
        exp_q.delete();
    endtask

    int   lat;
    int   latNoStall;
    logic shr;
    int   wBase, iBase, iwBase, gBase, sBase, aBase;

    initial begin
        reset        = 1'b0;
        busRequest   = 1'b0;
        busCommand   = CMD_NONE;
        busAddress   = '0;
        busDataReady = 1'b0;
        mValid       = 1'b0;
        mTag         = '0;
        mIndex       = '0;
        mState       = INV;
        for (int i = 0; i < 4; i++) mData[i] = 16'hA000 + DW'(i);

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_ack",      busAcknowledge,   0);
        check("rst_shared",   busShared,        0);
        check("rst_flush",    busFlush,         0);
        check("rst_valid",    busDataValid,     0);
        check("rst_data",     busDataOut,       0);
        check("rst_write",    snoopyWriteState, 0);
        check("rst_inval",    invalidateEnable, 0);
        check("rst_index",    snoopyIndex,      0);
        check("rst_offset",   snoopyOffset,     0);
        check("rst_tag",      snoopyTagIn,      0);
        check("rst_statein",  snoopyStateIn,    INV);
        check("rst_debug",    debugState,       0);
        reset = 1'b1;

        // Miss: empty cache, BUS_READ at 0x5A (tag 1, index 6, offset 2)
        wBase = writeCount; iBase = invCount;
        runTxn(CMD_READ, 14'h005A, 100, 0, lat, shr);
        endReq();
        check("miss_latency", lat, 2);
        check("miss_shared",  shr, 0);
        check("miss_writes",  writeCount - wBase, 0);
        check("miss_inval",   invCount - iBase, 0);
        check("miss_tag",     snoopyTagIn, 8'h01);
        check("miss_index",   snoopyIndex, 4'h6);
        check("miss_offset",  snoopyOffset, 2'h2);

        // Shared hit, BUS_READ_EXCLUSIVE -> invalidate
        mValid = 1'b1; mTag = 8'h12; mIndex = 4'd3; mState = SHR;
        wBase = writeCount; iBase = invCount; iwBase = invWithWrite;
        runTxn(CMD_READX, {8'h12, 4'd3, 2'd1}, 100, 0, lat, shr);
        endReq();
        check("rdx_latency",     lat, 3);
        check("rdx_shared",      shr, 1);
        check("rdx_writes",      writeCount - wBase, 1);
        check("rdx_new_state",   lastWriteState, INV);
        check("rdx_write_cycle", writeRel, 2);
        check("rdx_inval",       invCount - iBase, 1);
        check("rdx_inval_same",  invWithWrite - iwBase, 1);

        // Modified hit, BUS_READ, no backpressure
        mTag = 8'h34; mIndex = 4'd9; mState = MOD;
        wBase = writeCount; iBase = invCount; gBase = gotQ.size(); sBase = stallQ.size();
        runTxn(CMD_READ, {8'h34, 4'd9, 2'd2}, 100, 0, lat, shr);
        endReq();
        latNoStall = lat;
        check("flush_latency",     lat, 7);
        check("flush_shared",      shr, 1);
        checkFlushWords("flush", gBase, 2, 1'b0);
        check("flush_stalls",      stallQ.size() - sBase, 0);
        check("flush_writes",      writeCount - wBase, 1);
        check("flush_new_state",   lastWriteState, SHR);
        check("flush_write_cycle", writeRel, 6);
        check("flush_inval",       invCount - iBase, 0);

        // Same flush with busDataReady low for 3 cycles while word 1 is presented
        wBase = writeCount; gBase = gotQ.size(); sBase = stallQ.size();
        runTxn(CMD_READ, {8'h34, 4'd9, 2'd2}, 3, 5, lat, shr);
        endReq();
        check("bp_latency",     lat, 10);
        check("bp_delta",       lat - latNoStall, 3);
        check("bp_shared",      shr, 1);
        checkFlushWords("bp", gBase, 0, 1'b1);
        check("bp_stall_count", stallQ.size() - sBase, 3);
        if (stallQ.size() >= sBase + 3) begin
            for (int i = 0; i < 3; i++) check($sformatf("bp_stall%0d_word", i), stallQ[sBase+i], 16'hA001);
        end
        check("bp_writes",      writeCount - wBase, 1);
        check("bp_write_cycle", writeRel, 9);

        // Reset asserted while word 3 is on the bus
        wBase = writeCount; gBase = gotQ.size(); aBase = ackCount;
        @(posedge clock); #1;
        busRequest   = 1'b1;
        busCommand   = CMD_READ;
        busAddress   = {8'h34, 4'd9, 2'd0};
        reqCycle     = cyc;
        busDataReady = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_flush", busFlush,         0);
        check("mid_rst_valid", busDataValid,     0);
        check("mid_rst_data",  busDataOut,       0);
        check("mid_rst_write", snoopyWriteState, 0);
        check("mid_rst_ack",   busAcknowledge,   0);
        check("mid_rst_words", gotQ.size() - gBase, 3);
        busRequest   = 1'b0;
        busDataReady = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("mid_rst_no_write", writeCount - wBase, 0);
        check("mid_rst_no_ack",   ackCount - aBase, 0);

        // BUS_INVALIDATE on the still-Modified line: flushed, then invalidated
        wBase = writeCount; iBase = invCount; iwBase = invWithWrite; gBase = gotQ.size();
        runTxn(CMD_INV, {8'h34, 4'd9, 2'd1}, 100, 0, lat, shr);
        endReq();
        check("inv_latency",   lat, 7);
        check("inv_shared",    shr, 1);
        checkFlushWords("inv", gBase, 2, 1'b0);
        check("inv_writes",    writeCount - wBase, 1);
        check("inv_new_state", lastWriteState, INV);
        check("inv_inval",     invCount - iBase, 1);
        check("inv_inval_same", invWithWrite - iwBase, 1);

        // BUS_NONE on a missing tag, then BUS_READ back-to-back on a Shared line
        mState = SHR;
        wBase = writeCount; iBase = invCount; gBase = gotQ.size();
        runTxn(CMD_NONE, {8'h77, 4'd9, 2'd0}, 100, 0, lat, shr);
        check("none_latency", lat, 2);
        check("none_shared",  shr, 0);
        runTxn(CMD_READ, {8'h34, 4'd9, 2'd3}, 100, 0, lat, shr);
        endReq();
        check("b2b_latency",   lat, 3);
        check("b2b_shared",    shr, 1);
        check("b2b_writes",    writeCount - wBase, 1);
        check("b2b_new_state", lastWriteState, SHR);
        check("b2b_inval",     invCount - iBase, 0);
        check("b2b_no_flush",  gotQ.size() - gBase, 0);
        repeat (2) @(posedge clock);
        #1;
        check("end_idle",       debugState[2:0], 0);
        check("flush_valid_eq", flushSkew, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
